// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry helpers, address bit reversal, reader states.
package fft_pkg;

    // Complex samples are packed two per BRAM word.
    function automatic int unsigned ramlen_f(input int unsigned points);
        return points / 2;
    endfunction

    // Word address width for a frame of 2**stages points.
    function automatic int unsigned ramaddr_f(input int unsigned stages);
        return stages - 1;
    endfunction

    // Reverse the low 'width' bits of value; bits above width are returned as 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(width)) begin
                r[5'(i)] = value[5'(int'(width) - 1 - i)];
            end
        end
        return r;
    endfunction

    // Result reader states.
    typedef logic [1:0] reader_state_t;
    localparam reader_state_t ST_IDLE  = 2'd0;
    localparam reader_state_t ST_READ  = 2'd1;
    localparam reader_state_t ST_DRAIN = 2'd2;
    localparam reader_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry stream buffer: head register drives the stream, skid register absorbs one extra word.
module axis_skid_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count_c
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             pop;

    assign pop     = out_valid & out_ready;
    assign count_c = {1'b0, out_valid} + {1'b0, skid_valid};

    // Head/skid update; the caller never pushes into a full buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= push_data;
                    end else begin
                        skid_valid <= 1'b1;
                        skid_data  <= push_data;
                    end
                end
                2'b01: begin
                    if (skid_valid) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skid_valid) begin
                        out_data  <= skid_data;
                        skid_data <= push_data;
                    end else begin
                        out_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Unloads a finished FFT frame from BRAM port B and streams it as AXI4-Stream beats.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int unsigned POINTS    = 1024,
    parameter int unsigned STAGES    = 10,
    parameter int unsigned WORDLEN   = 32,
    parameter int unsigned MAXSHIFTS = 8,
    parameter int unsigned BITREV    = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [MAXSHIFTS-1:0] shifts_i,
    output logic                 bram_en_o,
    output logic                 bram_we_o,
    output logic [STAGES-2:0]    bram_addr_o,
    output logic [WORDLEN-1:0]   bram_wdata_o,
    input  logic [WORDLEN-1:0]   bram_rdata_i,
    output logic [WORDLEN-1:0]   m_axis_tdata,
    output logic [MAXSHIFTS-1:0] m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned RAMLEN = ramlen_f(POINTS);
    localparam int unsigned ADDR_W = ramaddr_f(STAGES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAMLEN - 1);

    reader_state_t        state, state_next;
    logic [ADDR_W-1:0]    cnt, cnt_next;
    logic [ADDR_W-1:0]    cap_cnt;
    logic                 inflight;
    logic                 issue;
    logic                 pop;
    logic                 credit_ok;
    logic [1:0]           occ;
    logic [MAXSHIFTS-1:0] tuser;
    logic                 busy;
    logic                 done;

    // A new read may issue only if its word is guaranteed a FIFO slot on arrival.
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;

    // Next-state, read issue and address counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_READ;
                    cnt_next   = '0;
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_next = ST_DRAIN;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight && (occ == {1'b0, pop})) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters, in-flight tracking and registered status.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap_cnt  <= '0;
            inflight <= 1'b0;
            tuser    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            inflight <= issue;
            if (state == ST_IDLE && start_i) begin
                tuser   <= shifts_i;
                cap_cnt <= '0;
            end else if (inflight) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
        end
    end

    // Output buffer carries the data word plus its tlast flag.
    axis_skid_fifo #(
        .WIDTH (WORDLEN + 1)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (inflight),
        .push_data ({(cap_cnt == LAST_ADDR), bram_rdata_i}),
        .out_valid (m_axis_tvalid),
        .out_data  ({m_axis_tlast, m_axis_tdata}),
        .out_ready (m_axis_tready),
        .count_c   (occ)
    );

    assign bram_en_o    = issue;
    assign bram_we_o    = 1'b0;
    assign bram_wdata_o = '0;
    assign bram_addr_o  = (BITREV != 0) ? ADDR_W'(bit_reverse(32'(cnt), ADDR_W)) : cnt;
    assign m_axis_tuser = tuser;
    assign busy_o       = busy;
    assign done_o       = done;

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench: 8-point frames through a bit-reversing and a linear reader side by side.
module tb_fft_result_reader;

    logic clk;
    logic rstn;
    logic start;
    logic tready;
    logic [7:0] shifts;

    logic        bram_en    [2];
    logic        bram_we    [2];
    logic [1:0]  bram_addr  [2];
    logic [31:0] bram_wdata [2];
    logic [31:0] bram_rdata [2];
    logic [31:0] tdata      [2];
    logic [7:0]  tuser      [2];
    logic        tlast      [2];
    logic        tvalid     [2];
    logic        busy       [2];
    logic        done       [2];

    int errors = 0;
    int checks = 0;

    // Instance 0 reads in bit-reversed order, instance 1 linearly.
    fft_result_reader #(.POINTS(8), .STAGES(3), .WORDLEN(32), .MAXSHIFTS(8), .BITREV(1)) u_rev (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .shifts_i(shifts),
        .bram_en_o(bram_en[0]), .bram_we_o(bram_we[0]), .bram_addr_o(bram_addr[0]),
        .bram_wdata_o(bram_wdata[0]), .bram_rdata_i(bram_rdata[0]),
        .m_axis_tdata(tdata[0]), .m_axis_tuser(tuser[0]), .m_axis_tlast(tlast[0]),
        .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready),
        .busy_o(busy[0]), .done_o(done[0]));

    fft_result_reader #(.POINTS(8), .STAGES(3), .WORDLEN(32), .MAXSHIFTS(8), .BITREV(0)) u_lin (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .shifts_i(shifts),
        .bram_en_o(bram_en[1]), .bram_we_o(bram_we[1]), .bram_addr_o(bram_addr[1]),
        .bram_wdata_o(bram_wdata[1]), .bram_rdata_i(bram_rdata[1]),
        .m_axis_tdata(tdata[1]), .m_axis_tuser(tuser[1]), .m_axis_tlast(tlast[1]),
        .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready),
        .busy_o(busy[1]), .done_o(done[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: word k holds 32'hA0 + k, one-cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (bram_en[d]) bram_rdata[d] <= 32'hA0 + 32'(bram_addr[d]);
        end
    end

    // Mid-cycle monitor: beat log, read-issue log and protocol counters.
    logic [31:0] bdata [2][64];
    logic        blast [2][64];
    logic [7:0]  buser [2][64];
    int          beat_n [2] = '{0, 0};
    int          en_n   [2] = '{0, 0};
    int          busy_n [2] = '{0, 0};
    int          done_n [2] = '{0, 0};
    int          outst  [2] = '{0, 0};
    int          issue_viol [2] = '{0, 0};
    int          stab_viol  [2] = '{0, 0};
    int          we_viol    [2] = '{0, 0};
    logic        was_stall  [2] = '{1'b0, 1'b0};
    logic [31:0] prev_data  [2];
    logic        prev_last  [2];
    logic [7:0]  prev_user  [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int p;
            p = (tvalid[d] && tready) ? 1 : 0;
            if (p == 1) begin
                bdata[d][beat_n[d] % 64] = tdata[d];
                blast[d][beat_n[d] % 64] = tlast[d];
                buser[d][beat_n[d] % 64] = tuser[d];
                beat_n[d] = beat_n[d] + 1;
            end
            if (bram_en[d]) begin
                if (outst[d] - p >= 2) issue_viol[d] = issue_viol[d] + 1;
                en_n[d] = en_n[d] + 1;
            end
            if (!rstn) outst[d] = 0;
            else outst[d] = outst[d] + (bram_en[d] ? 1 : 0) - p;
            if (was_stall[d] && rstn) begin
                if (!tvalid[d] || tdata[d] !== prev_data[d] || tlast[d] !== prev_last[d]
                    || tuser[d] !== prev_user[d]) stab_viol[d] = stab_viol[d] + 1;
            end
            was_stall[d] = tvalid[d] && !tready && rstn;
            prev_data[d] = tdata[d];
            prev_last[d] = tlast[d];
            prev_user[d] = tuser[d];
            if (busy[d]) busy_n[d] = busy_n[d] + 1;
            if (done[d]) done_n[d] = done_n[d] + 1;
            if (bram_we[d] !== 1'b0 || bram_wdata[d] !== 32'h0) we_viol[d] = we_viol[d] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks four logged beats starting at index base against the expected read order.
    task automatic check_frame(input int d, input int base, input logic [7:0] user);
        logic [1:0] order_rev [4];
        logic [1:0] k_exp;
        order_rev = '{2'd0, 2'd2, 2'd1, 2'd3};
        for (int k = 0; k < 4; k++) begin
            k_exp = (d == 0) ? order_rev[k] : 2'(k);
            check($sformatf("d%0d beat%0d data", d, k), bdata[d][(base + k) % 64], 32'hA0 + 32'(k_exp));
            check($sformatf("d%0d beat%0d last", d, k), blast[d][(base + k) % 64], (k == 3) ? 1'b1 : 1'b0);
            check($sformatf("d%0d beat%0d user", d, k), buser[d][(base + k) % 64], user);
        end
    endtask

    int b0, b1, e0, e1, bz0, dn0, dn1;

    initial begin
        rstn = 1'b0; start = 1'b0; tready = 1'b1; shifts = 8'd0;
        tick(); tick(); tick();
        check("reset tvalid", tvalid[0], 1'b0);
        check("reset busy", busy[0], 1'b0);
        check("reset done", done[0], 1'b0);
        check("reset en", bram_en[0], 1'b0);
        check("reset tuser", tuser[1], 8'd0);
        rstn = 1'b1;
        tick();

        // Bit-reversed frame at full throughput, cycle by cycle.
        b0 = beat_n[0]; b1 = beat_n[1]; bz0 = busy_n[0]; dn0 = done_n[0];
        shifts = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("A busy up", busy[0], 1'b1);
        check("A issue0 en", bram_en[0], 1'b1);
        check("A issue0 addr", bram_addr[0], 2'd0);
        check("A tvalid early", tvalid[0], 1'b0);
        tick();
        check("A issue1 addr", bram_addr[0], 2'd2);
        check("A tvalid still low", tvalid[0], 1'b0);
        tick();
        check("A first tvalid", tvalid[0], 1'b1);
        check("A beat0", tdata[0], 32'hA0);
        check("A issue2 addr", bram_addr[0], 2'd1);
        check("A lin beat0", tdata[1], 32'hA0);
        tick();
        check("A beat1", tdata[0], 32'hA2);
        check("A issue3 addr", bram_addr[0], 2'd3);
        tick();
        check("A beat2", tdata[0], 32'hA1);
        check("A no issue in drain", bram_en[0], 1'b0);
        tick();
        check("A beat3", tdata[0], 32'hA3);
        check("A tlast", tlast[0], 1'b1);
        check("A tuser", tuser[0], 8'd3);
        tick();
        check("A done", done[0], 1'b1);
        check("A tvalid after frame", tvalid[0], 1'b0);
        tick();
        check("A done pulse end", done[0], 1'b0);
        check("A busy down", busy[0], 1'b0);
        check("A busy cycles", busy_n[0] - bz0, 7);
        check("A done count", done_n[0] - dn0, 1);
        check_frame(0, b0, 8'd3);
        check_frame(1, b1, 8'd3);

        // Alternating tready.
        b0 = beat_n[0]; b1 = beat_n[1]; dn0 = done_n[0]; dn1 = done_n[1];
        shifts = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tready = ~tready;
            tick();
        end
        tready = 1'b1;
        tick(); tick(); tick();
        check("B beats rev", beat_n[0] - b0, 4);
        check("B beats lin", beat_n[1] - b1, 4);
        check("B done rev", done_n[0] - dn0, 1);
        check("B done lin", done_n[1] - dn1, 1);
        check_frame(0, b0, 8'd5);
        check_frame(1, b1, 8'd5);

        // Long stall right after start.
        b0 = beat_n[0]; e0 = en_n[0]; e1 = en_n[1]; dn0 = done_n[0];
        tready = 1'b0; shifts = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("C reads rev", en_n[0] - e0, 2);
        check("C reads lin", en_n[1] - e1, 2);
        check("C tvalid held", tvalid[0], 1'b1);
        check("C head word", tdata[0], 32'hA0);
        check("C head word lin", tdata[1], 32'hA0);
        tready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("C beats", beat_n[0] - b0, 4);
        check("C total reads", en_n[0] - e0, 4);
        check("C done", done_n[0] - dn0, 1);
        check_frame(0, b0, 8'hFF);

        // Second start during READ.
        b0 = beat_n[0]; b1 = beat_n[1]; e0 = en_n[0]; dn0 = done_n[0];
        shifts = 8'd1; start = 1'b1;
        tick();
        start = 1'b0; shifts = 8'd66;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("D beats rev", beat_n[0] - b0, 4);
        check("D beats lin", beat_n[1] - b1, 4);
        check("D reads", en_n[0] - e0, 4);
        check("D done", done_n[0] - dn0, 1);
        check_frame(0, b0, 8'd1);

        // Reset while the second beat is presented, then a fresh frame.
        dn0 = done_n[0];
        shifts = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("E beat2 shown", tdata[0], 32'hA2);
        rstn = 1'b0;
        tick();
        check("E abort tvalid", tvalid[0], 1'b0);
        check("E abort busy", busy[0], 1'b0);
        check("E abort busy lin", busy[1], 1'b0);
        check("E abort tuser", tuser[0], 8'd0);
        rstn = 1'b1;
        tick(); tick();
        check("E no done on abort", done_n[0] - dn0, 0);
        b0 = beat_n[0]; b1 = beat_n[1];
        shifts = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("E beats rev", beat_n[0] - b0, 4);
        check("E done", done_n[0] - dn0, 1);
        check_frame(0, b0, 8'd9);
        check_frame(1, b1, 8'd9);

        // Whole-run protocol counters.
        check("issue credit rev", issue_viol[0], 0);
        check("issue credit lin", issue_viol[1], 0);
        check("stall stability rev", stab_viol[0], 0);
        check("stall stability lin", stab_viol[1], 0);
        check("no writes rev", we_viol[0], 0);
        check("no writes lin", we_viol[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
